clk_gen_bank: RTL
=================

# clk_gen_bank

Multi-channel programmable clock divider, successor to the single fixed-ratio divider. Generates NCH independent divided clocks from `system_clk`, each with a runtime-programmable half-period, glitch-free ratio changes at period boundaries, clean start/stop, and one-cycle edge strobes for logic that stays on `system_clk`. Sits at the top of the CPU clocking tree, feeding the pipeline clock and slower peripheral clocks.

## Interface
- NCH, 2, number of independent divider channels (1..8)
- CW, 8, width of half-period counter and ratio fields
- DEFAULT_HALF, 2, reset value of every channel's active half-period (must be 1..2^CW-1)

- system_clk  in  1  source clock; all logic on rising edge
- reset_n  in  1  reset; asynchronous and active-low
- en  in  NCH  per-channel run enable, level
- div_half  in  NCH*CW  per-channel requested half-period in `system_clk` cycles; channel i at bits [i*CW +: CW]
- div_load  in  NCH  per-channel one-cycle pulse capturing `div_half` slice
- clk_out  out  NCH  divided clocks, registered
- rise_tick  out  NCH  one-cycle strobe, high in the first `system_clk` cycle `clk_out` is high
- pending  out  NCH  high while a loaded ratio awaits its period boundary
- running  out  NCH  high while channel is in RUN or STOPPING

## Operation
- Per channel state: IDLE, RUN, STOPPING.
- Effective half-period H = active ratio, with 0 treated as 1 (period 2, 50% duty). Period always 2*H, duty exactly 50%.
- IDLE: `clk_out`=0, counter=0. `en`=1 sampled → RUN, counter cleared, `clk_out` stays 0.
- RUN: counter increments each cycle; when counter == H-1, counter←0 and `clk_out` toggles. `en`=0 sampled → STOPPING if `clk_out`=1, else IDLE immediately (counter cleared).
- STOPPING: counts on until the high phase ends; at that falling toggle → IDLE. `en`=1 sampled in STOPPING → RUN with no phase disturbance.
- `div_load` in IDLE: slice written directly to active ratio; `pending` stays 0.
- `div_load` in RUN/STOPPING: slice captured into shadow register, `pending`←1. Shadow copied to active at the next falling toggle (high→low), `pending`←0. Ratio never changes mid-period.
- Simultaneous `div_load` and falling toggle: old shadow applied; new value captured; `pending` remains 1.
- Repeated loads before the boundary: last one wins.
- Counter compare uses CW-bit unsigned arithmetic; no wider intermediate needed.
- Channels fully independent; no cross-channel phase alignment.

## Timing
- Reset (async assert, sync to `system_clk` not required internally): `clk_out`=0, `rise_tick`=0, `pending`=0, `running`=0, active ratio=DEFAULT_HALF, shadow=0, all channels IDLE.
- `en` sampled high at edge E0: `running`=1 after E0; `clk_out` rises at E0+H, falls at E0+2H, rises E0+3H, ...
- `rise_tick` asserts at the same edge `clk_out` rises, deasserts one edge later (for H=1, `rise_tick` high one cycle per 2).
- `pending` clears at the same edge the new ratio takes effect; first low phase after that edge already uses the new H.
- Stop latency: at most H-1+1 cycles after `en` falls; `running` drops at the edge `clk_out` falls.
- Reset mid-period: all outputs go 0 immediately (asynchronous), runt pulse on `clk_out` accepted by design.

## Configuration
- CLK_GEN_FALL_TICK_EN defined: adds output `fall_tick` (NCH) asserted for one cycle at the edge `clk_out` falls, including the final fall when stopping; reset value 0.
- Undefined: port and its logic absent; all other behaviour identical.

## Structure
- Package `clk_gen_pkg`: channel state encoding (IDLE/RUN/STOPPING, 2-bit), DEFAULT_HALF default, max NCH constant.
- Sub-module `clk_gen_chan`: one channel (state, counter, active/shadow ratio, outputs), instantiated NCH times by generate; top only slices buses.

## Test plan
- Reset release, NCH=2, DEFAULT_HALF=2, en=2'b01 → ch0 `clk_out` period 4 cycles, first rise 2 cycles after en sampled; ch1 stays 0, `running`=2'b01.
- Ch0 running H=2, load 3 mid-high-phase → `pending`=1 until next fall; subsequent periods 6 cycles, no short pulse.
- Load 0 while idle, enable → `clk_out` toggles every cycle, `rise_tick` every 2nd cycle.
- Drop `en` one cycle after a rise with H=4 → `clk_out` holds high 4 cycles total, then 0; `running` falls on that edge; re-assert during STOPPING → period uninterrupted.
- Load 5 then 7 before boundary, plus load on the exact boundary cycle → 7 applied, boundary load retained with `pending`=1.
- Assert `reset_n`=0 mid-high-phase → all outputs 0 without waiting for a clock edge; with CLK_GEN_FALL_TICK_EN, `fall_tick` pulses once per fall including stop.

Source files
------------

// File: rtl/clk_gen_pkg.sv
// Shared definitions for the clk_gen_bank divider bank: channel state encoding and defaults.
package clk_gen_pkg;
    localparam int MAX_NCH  = 8;
    localparam int DEF_HALF = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STOP = 2'd2
    } chan_state_t;
endpackage

// File: rtl/clk_gen_chan.sv
// One programmable divider channel: 50% duty, ratio changes only at falling edges.
// Optional fall_tick output when CLK_GEN_FALL_TICK_EN is defined.
module clk_gen_chan
    import clk_gen_pkg::*;
#(
    parameter int CW           = 8,
    parameter int DEFAULT_HALF = DEF_HALF
) (
    input  logic          system_clk,
    input  logic          reset_n,
    input  logic          en,
    input  logic [CW-1:0] div_half,
    input  logic          div_load,
    output logic          clk_out,
    output logic          rise_tick,
    output logic          pending,
`ifdef CLK_GEN_FALL_TICK_EN
    output logic          fall_tick,
`endif
    output logic          running
);
    chan_state_t   state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [CW-1:0] act, act_n;
    logic [CW-1:0] shd, shd_n;
    logic [CW-1:0] h;
    logic          clk_n, rise_n, pend_n, tog;
`ifdef CLK_GEN_FALL_TICK_EN
    logic          fall_n;
`endif

    assign h       = (act == '0) ? CW'(1) : act;
    assign tog     = (cnt == h - CW'(1));
    assign running = (state != ST_IDLE);

    always_ff @(posedge system_clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            act       <= CW'(DEFAULT_HALF);
            shd       <= '0;
            clk_out   <= 1'b0;
            rise_tick <= 1'b0;
            pending   <= 1'b0;
`ifdef CLK_GEN_FALL_TICK_EN
            fall_tick <= 1'b0;
`endif
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            act       <= act_n;
            shd       <= shd_n;
            clk_out   <= clk_n;
            rise_tick <= rise_n;
            pending   <= pend_n;
`ifdef CLK_GEN_FALL_TICK_EN
            fall_tick <= fall_n;
`endif
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        act_n   = act;
        shd_n   = shd;
        clk_n   = clk_out;
        rise_n  = 1'b0;
        pend_n  = pending;
`ifdef CLK_GEN_FALL_TICK_EN
        fall_n  = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                cnt_n = '0;
                clk_n = 1'b0;
                if (div_load) act_n = div_half;
                if (en) state_n = ST_RUN;
            end
            default: begin
                if (!en && !clk_out) begin
                    // Stopping in the low phase: nothing in flight, so resolve
                    // any requested ratio straight into the active one.
                    state_n = ST_IDLE;
                    cnt_n   = '0;
                    pend_n  = 1'b0;
                    act_n   = div_load ? div_half : (pending ? shd : act);
                    if (div_load) shd_n = div_half;
                end else begin
                    state_n = en ? ST_RUN : ST_STOP;
                    cnt_n   = cnt + CW'(1);
                    if (div_load) begin
                        shd_n  = div_half;
                        pend_n = 1'b1;
                    end
                    if (tog) begin
                        cnt_n  = '0;
                        clk_n  = ~clk_out;
                        rise_n = ~clk_out;
`ifdef CLK_GEN_FALL_TICK_EN
                        fall_n = clk_out;
`endif
                        if (clk_out) begin
                            // Period boundary: the previously captured shadow wins,
                            // a load on this same edge stays pending.
                            if (pending) act_n = shd;
                            pend_n = div_load;
                            if (!en) begin
                                state_n = ST_IDLE;
                                pend_n  = 1'b0;
                                if (div_load) act_n = div_half;
                            end
                        end
                    end
                end
            end
        endcase
    end
endmodule

// File: rtl/clk_gen_bank.sv
// Bank of NCH independent programmable clock dividers on system_clk.
// Define CLK_GEN_FALL_TICK_EN to add the per-channel fall_tick output.
module clk_gen_bank
    import clk_gen_pkg::*;
#(
    parameter int NCH          = 2,
    parameter int CW           = 8,
    parameter int DEFAULT_HALF = DEF_HALF
) (
    input  logic              system_clk,
    input  logic              reset_n,
    input  logic [NCH-1:0]    en,
    input  logic [NCH*CW-1:0] div_half,
    input  logic [NCH-1:0]    div_load,
    output logic [NCH-1:0]    clk_out,
    output logic [NCH-1:0]    rise_tick,
    output logic [NCH-1:0]    pending,
`ifdef CLK_GEN_FALL_TICK_EN
    output logic [NCH-1:0]    fall_tick,
`endif
    output logic [NCH-1:0]    running
);
    for (genvar g = 0; g < NCH; g++) begin : g_chan
        clk_gen_chan #(
            .CW           (CW),
            .DEFAULT_HALF (DEFAULT_HALF)
        ) u_chan (
            .system_clk (system_clk),
            .reset_n    (reset_n),
            .en         (en[g]),
            .div_half   (div_half[g*CW +: CW]),
            .div_load   (div_load[g]),
            .clk_out    (clk_out[g]),
            .rise_tick  (rise_tick[g]),
            .pending    (pending[g]),
`ifdef CLK_GEN_FALL_TICK_EN
            .fall_tick  (fall_tick[g]),
`endif
            .running    (running[g])
        );
    end
endmodule
